// File: rtl/panel_key_event_ctrl.sv
// Front-panel key debouncer, round-robin event arbiter and event FIFO on an Avalon-MM slave.
// Optional auto-repeat on held keys is built when PANEL_KEY_REPEAT_EN is defined.
module panel_key_event_ctrl #(
  parameter int NKEYS      = 13,
  parameter int TICK_DIV   = 50000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MCLK_reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic [1:0]       avs_ctrl_address,
  input  logic             avs_ctrl_read,
  output logic [31:0]      avs_ctrl_readdata,
  input  logic             avs_ctrl_write,
  input  logic [31:0]      avs_ctrl_writedata,
  output logic             ins_irq_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NKEYS-1:0] sync1, sync2, stable, pending, key_edge, rpt;
  logic [NKEYS-1:0] press_ev, rel_ev, flip, rpt_set, grant_vec, collision;
  logic [2:0]       hist [NKEYS];
  logic [PW-1:0]    presc;
  logic             tick;
  logic             enable, irq_en, overflow;
  logic [6:0]       mem [FIFO_DEPTH];
  logic [6:0]       head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [5:0]       count;
  logic [4:0]       ptr, win;
  logic [5:0]       idx;
  logic             found, grant, pop, flush, full;
  logic [31:0]      edge_ext, rpt_ext, pend_ext, rd_mux;
  logic             unused;

  assign unused   = ^avs_ctrl_writedata[31:2];
  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign pop      = avs_ctrl_read && (avs_ctrl_address == 2'd0) && (count != 6'd0);
  assign flush    = avs_ctrl_write && (avs_ctrl_address == 2'd3);
  assign full     = (count == 6'(FIFO_DEPTH));
  assign pend_ext = 32'(pending);
  assign edge_ext = 32'(key_edge);
  assign rpt_ext  = 32'(rpt);
  assign head     = mem[rd_ptr];
  assign flip     = press_ev | rel_ev;

  // The history window is the three stored samples plus the current synced level.
  always_comb begin
    press_ev = '0;
    rel_ev   = '0;
    for (int k = 0; k < NKEYS; k++) begin
      press_ev[k] = tick && ({hist[k], sync2[k]} == 4'b0000) && !stable[k];
      rel_ev[k]   = tick && ({hist[k], sync2[k]} == 4'b1111) && stable[k];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NKEYS; i++) begin
      idx = {1'b0, ptr} + 6'(i);
      if (idx >= 6'(NKEYS)) idx = idx - 6'(NKEYS);
      if (!found && pend_ext[idx[4:0]]) begin
        found = 1'b1;
        win   = idx[4:0];
      end
    end
  end

  assign grant = enable && found && (!full || pop) && !flush;

  always_comb begin
    grant_vec = '0;
    for (int k = 0; k < NKEYS; k++) grant_vec[k] = grant && (win == 5'(k));
  end

  // A flip that lands on an event still waiting (and not being granted now) loses the old one.
  assign collision = flip & pending & ~grant_vec;

`ifdef PANEL_KEY_REPEAT_EN
  logic [4:0]       hold [NKEYS];
  logic [NKEYS-1:0] rpt_req;

  always_comb begin
    rpt_req = '0;
    for (int k = 0; k < NKEYS; k++)
      rpt_req[k] = tick && stable[k] && !rel_ev[k] && (hold[k] == 5'd0);
  end

  assign rpt_set = rpt_req & (~pending | grant_vec);

  // Down-counter: 31 after the press tick gives the first repeat 32 ticks later, then every 8.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MCLK_reset) begin
      for (int k = 0; k < NKEYS; k++) hold[k] <= '0;
    end else if (tick) begin
      for (int k = 0; k < NKEYS; k++) begin
        if (press_ev[k])                hold[k] <= 5'd31;
        else if (rel_ev[k] || !stable[k]) hold[k] <= 5'd0;
        else if (hold[k] == 5'd0)       hold[k] <= 5'd7;
        else                            hold[k] <= hold[k] - 5'd1;
      end
    end
  end
`else
  assign rpt_set = '0;
`endif

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MCLK_reset) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '0;
      presc  <= '0;
      for (int k = 0; k < NKEYS; k++) hist[k] <= 3'b111;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        for (int k = 0; k < NKEYS; k++) hist[k] <= {hist[k][1:0], sync2[k]};
        stable <= (stable | press_ev) & ~rel_ev;
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MCLK_reset) begin
      pending  <= '0;
      key_edge <= '0;
      rpt      <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (|collision);
      for (int k = 0; k < NKEYS; k++) begin
        if (flip[k]) begin
          pending[k]  <= 1'b1;
          key_edge[k] <= press_ev[k];
          rpt[k]      <= 1'b0;
        end else if (rpt_set[k]) begin
          pending[k]  <= 1'b1;
          key_edge[k] <= 1'b1;
          rpt[k]      <= 1'b1;
        end else if (grant_vec[k]) begin
          pending[k]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (grant) mem[wr_ptr] <= {rpt_ext[win], edge_ext[win], win};
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MCLK_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({grant, pop})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MCLK_reset) ptr <= '0;
    else if (grant)     ptr <= (win == 5'(NKEYS - 1)) ? 5'd0 : win + 5'd1;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_ctrl_address)
      2'd0: rd_mux = (count != 6'd0) ? {1'b1, overflow, 22'd0, head[6], 1'b0, head[5:0]}
                                     : {1'b0, overflow, 30'd0};
      2'd1: rd_mux = 32'(stable);
      2'd2: rd_mux = {30'd0, irq_en, enable};
      default: rd_mux = {26'd0, count};
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MCLK_reset) begin
      enable            <= 1'b0;
      irq_en            <= 1'b0;
      avs_ctrl_readdata <= '0;
      ins_irq_irq       <= 1'b0;
    end else begin
      if (avs_ctrl_write && (avs_ctrl_address == 2'd2)) begin
        enable <= avs_ctrl_writedata[0];
        irq_en <= avs_ctrl_writedata[1];
      end
      if (avs_ctrl_read) avs_ctrl_readdata <= rd_mux;
      ins_irq_irq <= irq_en && ((count != 6'd0) || overflow);
    end
  end

endmodule

// File: tb/tb_panel_key_event_ctrl.sv
// Self-checking bench for panel_key_event_ctrl: directed scenarios plus randomized key rounds
// compared against an event-level model (stable set, pending set, round-robin pointer, FIFO queue).
module tb_panel_key_event_ctrl;
  localparam int NK = 13;
  localparam int TD = 4;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [1:0]    addr;
  logic          rd, wr;
  logic [31:0]   wdata, rdata;
  logic          irq;
  int            cyc = 0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NK-1:0] m_stable, m_pend, m_edge;
  int            m_ptr;
  logic          m_ovf, m_en;
  logic [7:0]    m_fifo[$];

  panel_key_event_ctrl #(.NKEYS(NK), .TICK_DIV(TD), .FIFO_DEPTH(FD)) dut (
    .csi_MCLK_clk      (clk),
    .rsi_MCLK_reset    (rst),
    .key_n             (key_n),
    .avs_ctrl_address  (addr),
    .avs_ctrl_read     (rd),
    .avs_ctrl_readdata (rdata),
    .avs_ctrl_write    (wr),
    .avs_ctrl_writedata(wdata),
    .ins_irq_irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_stable = '0; m_pend = '0; m_edge = '0;
    m_ptr = 0; m_ovf = 1'b0; m_en = 1'b0;
    m_fifo.delete();
  endfunction

  // Grants happen one at a time from the pointer while enabled and there is room.
  function automatic void m_drain();
    int  k;
    bit  done;
    while (m_en && m_fifo.size() < FD && m_pend != '0) begin
      done = 0;
      for (int i = 0; i < NK; i++) begin
        k = (m_ptr + i) % NK;
        if (!done && m_pend[k]) begin
          m_fifo.push_back({2'b00, m_edge[k], 5'(k)});
          m_pend[k] = 1'b0;
          m_ptr = (k + 1) % NK;
          done = 1;
        end
      end
    end
  endfunction

  function automatic void m_apply(input logic [NK-1:0] mask);
    for (int k = 0; k < NK; k++) begin
      if (mask[k] != m_stable[k]) begin
        if (m_pend[k]) m_ovf = 1'b1;
        m_pend[k] = 1'b1;
        m_edge[k] = mask[k];
      end
    end
    m_stable = mask;
    m_drain();
  endfunction

  function automatic logic [31:0] m_pop();
    logic [31:0] r;
    logic [7:0]  e;
    if (m_fifo.size() == 0) return {1'b0, m_ovf, 30'd0};
    e = m_fifo.pop_front();
    r = {1'b1, m_ovf, 22'd0, e};
    m_drain();
    return r;
  endfunction

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
    addr = a; wdata = v; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    if (a == 2'd2) begin m_en = v[0]; m_drain(); end
  endtask

  task automatic do_reset();
    key_n = '1; rst = 1'b1;
    cyc_n(3);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic settle(input logic [NK-1:0] mask, input int n);
    key_n = ~mask;
    cyc_n(n);
    m_apply(mask);
  endtask

  task automatic chk_event(input string tag);
    logic [31:0] d, e;
    rd_reg(2'd0, d);
    e = m_pop();
    check(tag, d, e);
    cyc_n(1);
  endtask

  task automatic exp_event(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd_reg(2'd0, d);
    check(tag, d, exp);
    void'(m_pop());
    cyc_n(1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (m_fifo.size() > 0 && n < 40) begin
      chk_event(tag);
      n++;
    end
    chk_event({tag, "_empty"});
  endtask

  initial begin
    logic [31:0]   d;
    logic [NK-1:0] mask, g;
    rst = 1'b1; key_n = '1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    m_reset();
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_readdata", rdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    rd_reg(2'd1, d); check("rst_state", d, 32'h0);
    rd_reg(2'd3, d); check("rst_count", d, 32'h0);
    rd_reg(2'd2, d); check("rst_ctrl", d, 32'h0);
    rd_reg(2'd0, d); check("rst_event", d, 32'h0);

    // Single press of key 3
    wr_reg(2'd2, 32'h1);
    settle(NK'(1) << 3, 30);
    exp_event("k3_press", 32'h80000023);
    rd_reg(2'd1, d); check("k3_state", d, 32'h8);
    exp_event("k3_empty", 32'h0);
    settle('0, 9 * TD);
    drain("k3_release");

    // Two-tick glitch must not produce an event
    key_n = ~(NK'(1));
    cyc_n(2 * TD);
    key_n = '1;
    cyc_n(7 * TD);
    rd_reg(2'd1, d); check("glitch_state", d, 32'h0);
    rd_reg(2'd3, d); check("glitch_count", d, 32'h0);

    // Reset mid-operation drops queued events
    settle(NK'(1) << 7, 9 * TD);
    rd_reg(2'd3, d); check("pre_reset_count", d, 32'h1);
    do_reset();
    cyc_n(8 * TD);
    rd_reg(2'd3, d); check("post_reset_count", d, 32'h0);
    rd_reg(2'd0, d); check("post_reset_event", d, 32'h0);

    // Simultaneous presses arbitrated from pointer 0, pointer wraps after key 12
    wr_reg(2'd2, 32'h1);
    settle(NK'(13'h1021), 9 * TD);
    exp_event("rr_k0", 32'h80000020);
    exp_event("rr_k5", 32'h80000025);
    exp_event("rr_k12", 32'h8000002C);
    settle('0, 9 * TD);
    exp_event("rr_rel_k0", 32'h80000000);
    exp_event("rr_rel_k5", 32'h80000005);
    exp_event("rr_rel_k12", 32'h8000000C);

`ifndef PANEL_KEY_REPEAT_EN
    // Nine presses into an eight-entry FIFO
    settle(NK'(13'h01FF), 9 * TD);
    rd_reg(2'd3, d); check("full_count", d, 32'd8);
    exp_event("full_oldest", 32'h80000020);
    cyc_n(2);
    rd_reg(2'd3, d); check("full_refill_count", d, 32'd8);
    drain("full_rest");
    settle('0, 9 * TD);
    drain("full_release");

    // Interrupt, collision overflow and flush
    wr_reg(2'd2, 32'h3);
    settle(NK'(1) << 1, 9 * TD);
    check("irq_set", irq, 1'b1);
    settle(NK'(13'h01FE), 9 * TD);
    rd_reg(2'd3, d); check("ovf_full_count", d, 32'd8);
    settle(NK'(13'h01FC), 9 * TD);
    settle(NK'(13'h01FE), 9 * TD);
    exp_event("ovf_event", 32'hC0000021);
    wr_reg(2'd3, 32'h0);
    m_fifo.delete(); m_pend = '0; m_ovf = 1'b0;
    check("flush_irq_hold", irq, 1'b1);
    cyc_n(1);
    check("flush_irq_clear", irq, 1'b0);
    rd_reg(2'd3, d); check("flush_count", d, 32'h0);
    rd_reg(2'd0, d); check("flush_event", d, 32'h0);
    rd_reg(2'd2, d); check("ctrl_read", d, 32'h3);
    settle('0, 9 * TD);
    drain("post_flush_release");
    cyc_n(2);
    check("irq_idle", irq, 1'b0);
`endif

    // Randomized rounds: glitches on idle keys, then a random press set and its release
    for (int r = 0; r < 6; r++) begin
      mask = NK'($urandom);
      g = NK'($urandom) & ~mask;
      key_n = ~g;
      cyc_n($urandom_range(1, 3 * TD));
      key_n = '1;
      cyc_n(7 * TD);
      settle(mask, 9 * TD);
      rd_reg(2'd1, d); check("rnd_state", d, 32'(mask));
      rd_reg(2'd3, d); check("rnd_count", d, 32'(m_fifo.size()));
      drain("rnd_press");
      settle('0, 9 * TD);
      drain("rnd_release");
    end

`ifdef PANEL_KEY_REPEAT_EN
    begin
      int tstamp[4];
      int got = 0;
      int budget = 0;
      do_reset();
      wr_reg(2'd2, 32'h1);
      key_n = ~(NK'(1) << 2);
      while (got < 4 && budget < 400) begin
        rd_reg(2'd0, d);
        if (d[31]) begin
          check("rep_value", d, (got == 0) ? 32'h80000022 : 32'h800000A2);
          tstamp[got] = cyc;
          got++;
        end
        budget++;
      end
      check("rep_count", 32'(got), 32'd4);
      if (got == 4) begin
        check("rep_first_gap", 32'(tstamp[1] - tstamp[0]), 32'(32 * TD));
        check("rep_second_gap", 32'(tstamp[2] - tstamp[1]), 32'(8 * TD));
        check("rep_third_gap", 32'(tstamp[3] - tstamp[2]), 32'(8 * TD));
      end
      do_reset();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/panel_key_event_ctrl.md
Name: panel_key_event_ctrl

Overview:
- Front-panel key scheduler that sits between the raw button pads and the Avalon-MM register bus inside qsys. The pads are BUT_UP/DN/LFT/RHT/ENT/ESC, BUT_ST[5:0] and BUT_DN_RINk.
- Synchronises and debounces all keys with one shared sample tick.
- Round-robin arbitrates pending press/release events into an event FIFO that the host pops over the serial host bridge. An interrupt is raised while events are queued.

Parameters:
- NKEYS, 13, number of key inputs (1..32).
- TICK_DIV, 50000, csi_MCLK_clk cycles per debounce sample tick (≥2).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..32).

Ports:
- csi_MCLK_clk  input  1  system clock.
- rsi_MCLK_reset  input  1  reset, synchronous, active-high.
- key_n  input  NKEYS  raw keys, active-low (0 = pressed), asynchronous.
- avs_ctrl_address  input  2  register select.
- avs_ctrl_read  input  1  read strobe, one cycle per access.
- avs_ctrl_readdata  output  32  read data, valid the cycle after avs_ctrl_read (read latency 1).
- avs_ctrl_write  input  1  write strobe.
- avs_ctrl_writedata  input  32  write data.
- ins_irq_irq  output  1  level interrupt.

Behaviour:
- Reset state: all outputs 0.
  - Sync flops = all ones; stable state = all released; shift registers = all ones.
  - Prescaler = 0, pending = 0, FIFO empty, overflow = 0, ENABLE = 0, IRQ_EN = 0, round-robin pointer = 0.
  - Reset mid-operation discards every queued and pending event.
- Input path: two-flop synchroniser per key.
- Prescaler counts 0..TICK_DIV-1 and asserts a one-cycle tick at TICK_DIV-1, then wraps to 0.
- On each tick, every key shifts its synced level into a 4-bit history.
  - When the history is all 0 and the stable state is released: stable becomes pressed, pending[k] = 1, edge[k] = 1.
  - When the history is all 1 and the stable state is pressed: stable becomes released, pending[k] = 1, edge[k] = 0.
  - Debounce latency: 4 ticks plus 2 sync cycles; no event for a glitch shorter than 4 ticks.
- Pending collision: if pending[k] is already 1 when key k flips again, edge[k] is overwritten with the new edge and overflow is set (sticky).
- Arbiter, one grant per cycle:
  - Grant only when ENABLE = 1 and the FIFO is not full.
  - Search starts at the pointer and wraps NKEYS-1 to 0; the lowest index at or after the pointer wins.
  - The winner's entry {edge, key index[4:0]} is written to the FIFO and its pending bit is cleared.
  - The pointer moves to winner+1, wrapping to 0 after NKEYS-1.
  - A pending bit set in the same cycle as its grant stays set and carries the new edge.
- FIFO full: pending bits hold and no grant occurs; events are not lost unless a collision occurs.
- Registers:
  - addr 0 read: EVENT = {valid[31], overflow[30], 22'b0, repeat[7], 1'b0, edge[5], key[4:0]}.
    - If the FIFO is non-empty: valid = 1 and the head entry is popped.
    - If empty: valid = 0, low bits 0, no pop.
  - addr 1 read: STATE, bit k = stable pressed; upper bits 0.
  - addr 2 read/write: CTRL, bit0 ENABLE, bit1 IRQ_EN.
  - addr 3 write (any data): flush the FIFO, clear pending, clear overflow. Reads return {count[5:0]} zero-extended.
- Simultaneous events:
  - A pop and a push in the same cycle on a full FIFO are both allowed; the count is unchanged.
  - A flush in the same cycle as a grant: the flush wins and the granted entry is dropped.
  - Writes with address 0 or 1 are ignored.
- ins_irq_irq = IRQ_EN & (FIFO non-empty | overflow), registered, so it updates one cycle after its source.

Optional Feature:
- Macro: PANEL_KEY_REPEAT_EN.
- When defined:
  - A per-key hold counter starts on a press.
  - After 32 ticks held, a repeat event is requested; further repeats follow every 8 ticks while the key stays pressed.
  - A repeat sets pending with edge = 1 and the repeat flag = 1, so EVENT bit7 = 1.
  - The counter clears on release or reset.
  - A repeat request is dropped silently, with no overflow, if pending[k] is already set.
- When undefined: no hold counters exist and EVENT bit7 reads 0.

Test Plan:
- Reset with TICK_DIV=4 and CTRL=1, hold key_n[3]=0 for 30 cycles → EVENT read returns 0x80000023 (valid, edge=1, key 3); STATE bit3=1; the next EVENT read returns 0x00000000.
- Apply a 2-tick low glitch on key_n[0] → no event queued; STATE=0; count=0.
- Press keys 12, 0 and 5 within the same tick (pointer=0) → events pop in order key 0, key 5, key 12; the pointer ends at 0 after wrap.
- FIFO_DEPTH=8, CTRL=1, produce 9 press events without reading → count=8 and pending holds the ninth. One read then returns the oldest entry and the ninth is queued the next cycle. Overflow stays 0.
- CTRL=3, press key 1 → ins_irq_irq=1. Toggle key 1 twice while the FIFO is full → overflow=1 and EVENT bit30=1. Write addr 3 → count=0, ins_irq_irq=0 two cycles later.
- PANEL_KEY_REPEAT_EN defined, hold key 2 for 48 ticks → events in order: press 0x22 at debounce, repeat 0xA2 at tick +32, repeat 0xA2 at tick +40, repeat 0xA2 at tick +48.
